// File: rtl/mailbox_pkg.sv
// Shared register map, status/control bit positions and the STATUS byte packer
// for the CPU-bus mailbox.
package mailbox_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_TXCNT  = 2'd3
  } reg_e;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_OVF      = 2;
  localparam int ST_TX_DROP     = 3;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int MAX_CH = 4;

  function automatic logic [7:0] status_byte(input logic tx_drop, input logic rx_ovf,
                                             input logic tx_full, input logic rx_nonempty);
    logic [7:0] s;
    s                 = 8'h00;
    s[ST_TX_DROP]     = tx_drop;
    s[ST_RX_OVF]      = rx_ovf;
    s[ST_TX_FULL]     = tx_full;
    s[ST_RX_NONEMPTY] = rx_nonempty;
    return s;
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// 8-bit synchronous FIFO with flush; a push while full is accepted only when a pop
// happens in the same clock. Head is exposed combinationally.
module mailbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign head_o    = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i && !reset_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_mailbox.sv
// Memory-mapped multi-channel byte mailbox between a Z80-style CPU bus and host
// byte streams: address decode, strobe edge detection, per-channel FIFOs and flags.
module bus_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFE0,
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mreq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [15:0]           addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  hit,
  output logic [NUM_CH-1:0]     tx_valid,
  output logic [8*NUM_CH-1:0]   tx_data,
  input  logic [NUM_CH-1:0]     tx_ready,
  input  logic [NUM_CH-1:0]     rx_valid,
  input  logic [8*NUM_CH-1:0]   rx_data,
  output logic [NUM_CH-1:0]     rx_ready,
  output logic                  irq_n
);

  logic [15:0]       offset_s;
  logic [1:0]        ch_s;
  reg_e              reg_s;
  logic              wr_act_s, rd_act_s, wr_fire_s, rd_pop_s;
  logic              wr_prev_q, rd_prev_q, rd_arm_q;
  logic [1:0]        rd_ch_q;
  logic              irq_n_q;
  logic [NUM_CH-1:0] rx_ne_s;
  logic [7:0]        ch_rd_s [MAX_CH];

  assign offset_s  = addr - BASE_ADDR;
  assign hit       = !mreq_n && (offset_s < 16'(4 * NUM_CH));
  assign ch_s      = offset_s[3:2];
  assign reg_s     = reg_e'(offset_s[1:0]);
  assign wr_act_s  = hit && !wr_n;
  assign rd_act_s  = hit && !rd_n && (reg_s == REG_DATA);
  assign wr_fire_s = wr_act_s && !wr_prev_q;
  assign rd_pop_s  = rd_arm_q && !rd_act_s;

  // Reset primes both detectors as "already active" so a strobe spanning reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
      rd_arm_q  <= 1'b0;
      rd_ch_q   <= 2'd0;
    end else begin
      wr_prev_q <= wr_act_s;
      rd_prev_q <= rd_act_s;
      if (rd_act_s && !rd_prev_q) begin
        rd_arm_q <= 1'b1;
        rd_ch_q  <= ch_s;
      end else if (!rd_act_s) begin
        rd_arm_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic       sel_s, tx_push_s, tx_pop_s, rx_pop_s, clr_s, flush_s, cnt_clr_s;
    logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [7:0] rx_head_s, rd_data_s;
    logic       tx_drop_q, rx_ovf_q;
    logic [7:0] txcnt_q;

    assign sel_s     = wr_fire_s && (ch_s == 2'(i));
    assign tx_push_s = sel_s && (reg_s == REG_DATA);
    assign clr_s     = sel_s && (reg_s == REG_CTRL) && din[CTRL_CLR];
    assign flush_s   = sel_s && (reg_s == REG_CTRL) && din[CTRL_FLUSH];
    assign cnt_clr_s = sel_s && (reg_s == REG_TXCNT);
    assign tx_pop_s  = !tx_empty_s && tx_ready[i];
    assign rx_pop_s  = rd_pop_s && (rd_ch_q == 2'(i));

    mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk_i(clk), .reset_i(reset), .push_i(tx_push_s), .pop_i(tx_pop_s), .flush_i(flush_s),
      .wdata_i(din), .head_o(tx_data[8*i +: 8]), .full_o(tx_full_s), .empty_o(tx_empty_s)
    );

    mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk_i(clk), .reset_i(reset), .push_i(rx_valid[i]), .pop_i(rx_pop_s), .flush_i(flush_s),
      .wdata_i(rx_data[8*i +: 8]), .head_o(rx_head_s), .full_o(rx_full_s), .empty_o(rx_empty_s)
    );

    assign tx_valid[i] = !tx_empty_s;
    assign rx_ready[i] = !rx_full_s;
    assign rx_ne_s[i]  = !rx_empty_s;
    assign ch_rd_s[i]  = rd_data_s;

    // Sticky errors: a new error in the clearing clock leaves the flag set; TXCNT clear beats increment.
    always_ff @(posedge clk) begin
      if (reset) begin
        tx_drop_q <= 1'b0;
        rx_ovf_q  <= 1'b0;
        txcnt_q   <= 8'h00;
      end else begin
        tx_drop_q <= (tx_drop_q && !clr_s) || (tx_push_s && tx_full_s && !tx_pop_s);
        rx_ovf_q  <= (rx_ovf_q && !clr_s) || (rx_valid[i] && rx_full_s && !rx_pop_s && !flush_s);
        if (cnt_clr_s)
          txcnt_q <= 8'h00;
        else if (tx_push_s && (!tx_full_s || tx_pop_s))
          txcnt_q <= txcnt_q + 8'd1;
        else
          txcnt_q <= txcnt_q;
      end
    end

    // Register read mux for this channel; DATA reads 0 while the RX FIFO is empty.
    always_comb begin
      rd_data_s = 8'h00;
      case (reg_s)
        REG_DATA:   rd_data_s = rx_empty_s ? 8'h00 : rx_head_s;
        REG_STATUS: rd_data_s = status_byte(tx_drop_q, rx_ovf_q, tx_full_s, !rx_empty_s);
        REG_TXCNT:  rd_data_s = txcnt_q;
        default:    rd_data_s = 8'h00;
      endcase
    end
  end

  for (genvar j = NUM_CH; j < MAX_CH; j++) begin : g_absent
    assign ch_rd_s[j] = 8'h00;
  end

  assign dout = (hit && !rd_n) ? ch_rd_s[ch_s] : 8'h00;

  // Interrupt is a registered view of RX occupancy across all channels.
  always_ff @(posedge clk) begin
    if (reset) irq_n_q <= 1'b1;
    else       irq_n_q <= !(|rx_ne_s);
  end

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_bus_mailbox.sv
// Scenario bench for bus_mailbox: expected TX/RX bytes are queued as stimulus is
// driven and compared when the DUT presents them.
module tb_bus_mailbox;

  localparam int NUM_CH = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0]         addr = 16'h0000;
  logic [7:0]          din = 8'h00;
  logic [7:0]          dout;
  logic                hit;
  logic [NUM_CH-1:0]   tx_valid;
  logic [8*NUM_CH-1:0] tx_data;
  logic [NUM_CH-1:0]   tx_ready = '0;
  logic [NUM_CH-1:0]   rx_valid = '0;
  logic [8*NUM_CH-1:0] rx_data = '0;
  logic [NUM_CH-1:0]   rx_ready;
  logic                irq_n;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] rx0_q[$];
  logic [7:0] rx1_q[$];

  bus_mailbox #(.BASE_ADDR(16'hFFE0), .NUM_CH(NUM_CH), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr),
    .din(din), .dout(dout), .hit(hit), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int nclk);
    addr = a; din = d; mreq_n = 1'b0; wr_n = 1'b0;
    repeat (nclk) step();
    wr_n = 1'b1; mreq_n = 1'b1;
    step();
  endtask

  task automatic cpu_read(input logic [15:0] a, input int nclk, output logic [7:0] d, output bit stable);
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = dout;
    stable = 1'b1;
    repeat (nclk) begin
      step();
      if (dout !== d) stable = 1'b0;
    end
    rd_n = 1'b1; mreq_n = 1'b1;
    step();
  endtask

  task automatic host_rx_push(input int ch, input logic [7:0] b);
    rx_valid[ch] = 1'b1;
    rx_data[8*ch +: 8] = b;
    step();
    rx_valid[ch] = 1'b0;
  endtask

  task automatic host_drain_tx0();
    tx_got.delete();
    tx_ready[0] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (!tx_valid[0]) break;
      tx_got.push_back(tx_data[7:0]);
      step();
    end
    tx_ready[0] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    reset = 1'b0;
    step();
    n_chk++; if (tx_valid !== 2'b00) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 00", tx_valid); end
    n_chk++; if (rx_ready !== 2'b11) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 11", rx_ready); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    addr = 16'hFFE7; mreq_n = 1'b0; #1;
    n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_top: got %b want 1", hit); end
    addr = 16'hFFE8; #1;
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_above: got %b want 0", hit); end
    addr = 16'hFFDF; #1;
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_below: got %b want 0", hit); end
    addr = 16'hFFE0; mreq_n = 1'b1; #1;
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_nomreq: got %b want 0", hit); end
  endtask

  task automatic test_single_write();
    logic [7:0] d; bit s;
    cpu_write(16'hFFE0, 8'h41, 3);
    tx_q.push_back(8'h41);
    n_chk++; if (tx_valid[0] !== 1'b1) begin n_fail++; $display("FAIL sw_tx_valid: got %b want 1", tx_valid[0]); end
    n_chk++; if (tx_data[7:0] !== tx_q[0]) begin n_fail++; $display("FAIL sw_tx_data: got %h want %h", tx_data[7:0], tx_q[0]); end
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL sw_txcnt: got %h want 01", d); end
    host_drain_tx0();
    n_chk++; if (tx_got.size() !== tx_q.size()) begin n_fail++; $display("FAIL sw_entries: got %0d want %0d", tx_got.size(), tx_q.size()); end
    while (tx_got.size() > 0 && tx_q.size() > 0) begin
      logic [7:0] g, e;
      g = tx_got.pop_front(); e = tx_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL sw_drain: got %h want %h", g, e); end
    end
    tx_q.delete();
  endtask

  task automatic test_tx_full_drop();
    logic [7:0] d, b; bit s;
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      cpu_write(16'hFFE0, b, 1);
      tx_q.push_back(b);
    end
    cpu_write(16'hFFE0, 8'hEE, 1);
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h0A) begin n_fail++; $display("FAIL full_status: got %h want 0a", d); end
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h11) begin n_fail++; $display("FAIL full_txcnt: got %h want 11", d); end
    cpu_write(16'hFFE2, 8'h01, 1);
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h02) begin n_fail++; $display("FAIL clr_status: got %h want 02", d); end
    host_drain_tx0();
    n_chk++; if (tx_got.size() !== 16) begin n_fail++; $display("FAIL full_entries: got %0d want 16", tx_got.size()); end
    while (tx_got.size() > 0 && tx_q.size() > 0) begin
      logic [7:0] g, e;
      g = tx_got.pop_front(); e = tx_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL full_drain: got %h want %h", g, e); end
    end
    tx_q.delete();
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL drained_status: got %h want 00", d); end
  endtask

  task automatic test_rx_irq_read();
    logic [7:0] d, e; bit s;
    host_rx_push(1, 8'h55); rx1_q.push_back(8'h55);
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_latency: got %b want 1", irq_n); end
    step();
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_assert: got %b want 0", irq_n); end
    cpu_read(16'hFFE4, 4, d, s);
    e = rx1_q.pop_front();
    n_chk++; if (d !== e) begin n_fail++; $display("FAIL rx_read: got %h want %h", d, e); end
    n_chk++; if (s !== 1'b1) begin n_fail++; $display("FAIL rx_stable: got %b want 1", s); end
    cpu_read(16'hFFE5, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rx_status: got %h want 00", d); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_release: got %b want 1", irq_n); end
    host_rx_push(1, 8'hA1); rx1_q.push_back(8'hA1);
    host_rx_push(1, 8'hA2); rx1_q.push_back(8'hA2);
    for (int k = 0; k < 2; k++) begin
      cpu_read(16'hFFE4, 4, d, s);
      e = rx1_q.pop_front();
      n_chk++; if (d !== e || s !== 1'b1) begin n_fail++; $display("FAIL rx_b2b: got %h stable %b want %h stable 1", d, s, e); end
    end
    cpu_read(16'hFFE5, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rx_b2b_status: got %h want 00", d); end
  endtask

  task automatic test_rx_full_concurrent();
    logic [7:0] d, e; bit s;
    for (int i = 0; i < 16; i++) begin
      host_rx_push(0, 8'h80 + 8'(i));
      rx0_q.push_back(8'h80 + 8'(i));
    end
    n_chk++; if (rx_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rxfull_ready: got %b want 0", rx_ready[0]); end
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL rxfull_irq: got %b want 0", irq_n); end
    addr = 16'hFFE0; mreq_n = 1'b0; rd_n = 1'b0;
    step(); step();
    e = rx0_q.pop_front();
    n_chk++; if (dout !== e) begin n_fail++; $display("FAIL conc_head: got %h want %h", dout, e); end
    rd_n = 1'b1; mreq_n = 1'b1;
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'hC0;
    step();
    rx_valid[0] = 1'b0;
    rx0_q.push_back(8'hC0);
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL conc_status: got %h want 01", d); end
    n_chk++; if (rx_ready[0] !== 1'b0) begin n_fail++; $display("FAIL conc_still_full: got %b want 0", rx_ready[0]); end
    host_rx_push(0, 8'hDD);
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h05) begin n_fail++; $display("FAIL ovf_status: got %h want 05", d); end
    cpu_write(16'hFFE2, 8'h01, 1);
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL ovf_clear: got %h want 01", d); end
    for (int k = 0; k < 2; k++) begin
      cpu_read(16'hFFE0, 2, d, s);
      e = rx0_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL full_rx_read: got %h want %h", d, e); end
    end
    cpu_write(16'hFFE2, 8'h02, 1);
    rx0_q.delete();
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL flush_status: got %h want 00", d); end
    n_chk++; if (rx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", rx_ready[0]); end
    cpu_read(16'hFFE0, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL empty_data: got %h want 00", d); end
  endtask

  task automatic test_txcnt_wrap();
    logic [7:0] d; bit s;
    cpu_write(16'hFFE3, 8'h5A, 1);
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL cnt_clear: got %h want 00", d); end
    tx_ready[0] = 1'b1;
    for (int i = 0; i < 255; i++) cpu_write(16'hFFE0, 8'(i), 1);
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'hFF) begin n_fail++; $display("FAIL cnt_255: got %h want ff", d); end
    cpu_write(16'hFFE0, 8'hFF, 1);
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL cnt_wrap: got %h want 00", d); end
    n_chk++; if (tx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got %b want 0", tx_valid[0]); end
    tx_ready[0] = 1'b0;
    cpu_read(16'hFFE1, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_nodrop: got %h want 00", d); end
    for (int i = 0; i < 3; i++) cpu_write(16'hFFE0, 8'h30 + 8'(i), 1);
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h03) begin n_fail++; $display("FAIL cnt_3: got %h want 03", d); end
    cpu_write(16'hFFE3, 8'h00, 1);
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL cnt_reclear: got %h want 00", d); end
    cpu_write(16'hFFE2, 8'h02, 1);
    n_chk++; if (tx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL tx_flush: got %b want 0", tx_valid[0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d; bit s;
    for (int i = 0; i < 16; i++) host_rx_push(1, 8'h60 + 8'(i));
    cpu_write(16'hFFE0, 8'h01, 1);
    cpu_write(16'hFFE0, 8'h02, 1);
    addr = 16'hFFE4; mreq_n = 1'b0; rd_n = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    n_chk++; if (rx_ready !== 2'b11) begin n_fail++; $display("FAIL mid_rx_ready: got %b want 11", rx_ready); end
    n_chk++; if (tx_valid !== 2'b00) begin n_fail++; $display("FAIL mid_tx_valid: got %b want 00", tx_valid); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL mid_irq_n: got %b want 1", irq_n); end
    host_rx_push(1, 8'h77); rx1_q.push_back(8'h77);
    rd_n = 1'b1; mreq_n = 1'b1;
    step();
    cpu_read(16'hFFE4, 2, d, s);
    n_chk++; if (d !== rx1_q[0]) begin n_fail++; $display("FAIL mid_nopop: got %h want %h", d, rx1_q[0]); end
    void'(rx1_q.pop_front());
    cpu_read(16'hFFE5, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_status: got %h want 00", d); end
    cpu_read(16'hFFE3, 1, d, s);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_txcnt: got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tx_full_drop();
    test_rx_irq_read();
    test_rx_full_concurrent();
    test_txcnt_wrap();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
